uart_rx_fifo: RTL and testbench

Runtime-configurable UART receiver with an integrated receive FIFO. It is the successor to the fixed-configuration receiver.
- Frame format and baud divider are driven by ports, not parameters.
- Adds 1/2 stop bits, framing-error, break and false-start detection, and overrun tracking.
- Sits between the pad-side rx line and the APB/bus register block, which pops entries through a valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - runtime-configurable UART receiver with first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic [15:0]      cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic [1:0]       cfg_parity_sel_i,
  input  logic             cfg_stop_bits_i,
  input  logic             err_clr_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_perr_o,
  output logic             rx_ferr_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             busy_o,
  output logic             break_o,
  output logic             overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP1    = 3'd4;
  localparam logic [2:0] S_STOP2    = 3'd5;
  localparam logic [2:0] S_BRK_WAIT = 3'd6;

  logic [2:0]       r_sync;
  logic [2:0]       r_state;
  logic [15:0]      r_cnt;
  logic [15:0]      r_div;
  logic [1:0]       r_bits;
  logic             r_par_en;
  logic [1:0]       r_psel;
  logic             r_stop2;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_data;
  logic             r_par_bit;
  logic             r_perr;
  logic             r_ferr;
  logic             r_stop_zero;
  logic             r_break;
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overrun;

  logic        w_rx;
  logic        w_start;
  logic        w_counting;
  logic [15:0] w_term;
  logic        w_bit_done;
  logic        w_par_err;
  logic        w_frame_end;
  logic        w_stops_zero;
  logic        w_is_break;
  logic        w_push;
  logic [9:0]  w_wdata;
  logic [9:0]  w_head;
  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;

  assign w_rx       = r_sync[2];
  assign w_start    = (r_state == S_IDLE) && cfg_en_i && r_sync[2] && !r_sync[1];
  assign w_counting = (r_state != S_IDLE) && (r_state != S_BRK_WAIT);
  // The start bit ends at half a period so every later sample lands mid-bit.
  assign w_term     = (r_state == S_START) ? (r_div >> 1) : r_div;
  assign w_bit_done = w_counting && (r_cnt == w_term);

  // Parity error for the bit currently on the line, against the latched mode.
  always_comb begin
    w_par_err = 1'b0;
    case (r_psel)
      2'b00:   w_par_err = (^r_data) ^ w_rx;
      2'b01:   w_par_err = ~((^r_data) ^ w_rx);
      2'b10:   w_par_err = w_rx;
      default: w_par_err = ~w_rx;
    endcase
  end

  assign w_frame_end  = w_bit_done && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));
  assign w_stops_zero = !w_rx && ((r_state == S_STOP1) || r_stop_zero);
  // r_par_bit stays 0 when no parity bit is configured, so it never blocks a break.
  assign w_is_break   = w_frame_end && (r_data == 8'd0) && !r_par_bit && w_stops_zero;
  assign w_push       = cfg_en_i && w_frame_end && !w_is_break;
  assign w_wdata      = {r_ferr | !w_rx, r_perr, r_data};

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop   = w_valid && rx_ready_i;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr];

  assign rx_data_o    = w_valid ? w_head[7:0] : 8'd0;
  assign rx_perr_o    = w_valid & w_head[8];
  assign rx_ferr_o    = w_valid & w_head[9];
  assign rx_valid_o   = w_valid;
  assign fifo_level_o = r_level;
  assign busy_o       = (r_state != S_IDLE);
  assign break_o      = r_break;
  assign overrun_o    = r_overrun;

  // Three-flop synchroniser for the asynchronous rx line, idle high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_sync <= 3'b111;
    else         r_sync <= {r_sync[1:0], rx_i};
  end

  // Baud counter: restarts on every bit boundary and sits at 0 when not receiving.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                       r_cnt <= 16'd0;
    else if (!w_counting || w_bit_done) r_cnt <= 16'd0;
    else                               r_cnt <= r_cnt + 16'd1;
  end

  // Receive FSM: frame configuration is frozen at start detect.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_div       <= 16'd0;
      r_bits      <= 2'd0;
      r_par_en    <= 1'b0;
      r_psel      <= 2'd0;
      r_stop2     <= 1'b0;
      r_bitcnt    <= 3'd0;
      r_data      <= 8'd0;
      r_par_bit   <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_stop_zero <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_break <= 1'b0;
      if (!cfg_en_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_div       <= cfg_div_i;
            r_bits      <= cfg_bits_i;
            r_par_en    <= cfg_parity_en_i;
            r_psel      <= cfg_parity_sel_i;
            r_stop2     <= cfg_stop_bits_i;
            r_bitcnt    <= 3'd0;
            r_data      <= 8'd0;
            r_par_bit   <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop_zero <= 1'b1;
            r_state     <= S_START;
          end
          S_START: if (w_bit_done) r_state <= w_rx ? S_IDLE : S_DATA;
          S_DATA: if (w_bit_done) begin
            r_data[r_bitcnt] <= w_rx;
            r_bitcnt         <= r_bitcnt + 3'd1;
            if (r_bitcnt == {1'b1, r_bits}) r_state <= r_par_en ? S_PARITY : S_STOP1;
          end
          S_PARITY: if (w_bit_done) begin
            r_par_bit <= w_rx;
            r_perr    <= w_par_err;
            r_state   <= S_STOP1;
          end
          S_STOP1: if (w_bit_done) begin
            r_ferr      <= r_ferr | !w_rx;
            r_stop_zero <= !w_rx;
            r_break     <= w_is_break;
            if (r_stop2)         r_state <= S_STOP2;
            else if (w_is_break) r_state <= S_BRK_WAIT;
            else                 r_state <= S_IDLE;
          end
          S_STOP2: if (w_bit_done) begin
            r_break <= w_is_break;
            r_state <= w_is_break ? S_BRK_WAIT : S_IDLE;
          end
          S_BRK_WAIT: if (w_rx) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because reads are gated by the level.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= w_wdata;
  end

  // FIFO pointers, level and sticky overrun; a full FIFO still accepts a push alongside a pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (err_clr_i)             r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a frame-level model
module tb_uart_rx_fifo;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_parity_en_i;
  logic [1:0]  cfg_parity_sel_i;
  logic        cfg_stop_bits_i;
  logic        err_clr_i;
  logic        rx_i;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o;
  logic        rx_ferr_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [3:0]  fifo_level_o;
  logic        busy_o;
  logic        break_o;
  logic        overrun_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_fall   = 0;
  int valid_rise = -1;
  int brk_cnt  = 0;
  logic prev_valid = 1'b0;

  uart_rx_fifo #(.FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_bits_i(cfg_bits_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_parity_sel_i(cfg_parity_sel_i), .cfg_stop_bits_i(cfg_stop_bits_i),
    .err_clr_i(err_clr_i), .rx_i(rx_i), .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o),
    .rx_ferr_o(rx_ferr_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o), .break_o(break_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rx_valid_o && !prev_valid) valid_rise = cyc;
    prev_valid = rx_valid_o;
    if (break_o) brk_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level model: returns {is_break, ferr, perr, data}.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input int nbits, input bit pen,
                                              input logic [1:0] psel, input bit pbit, input bit two,
                                              input bit s1, input bit s2);
    logic [7:0] m;
    bit want, perr, ferr, brk;
    m    = d & 8'((1 << nbits) - 1);
    want = (psel == 2'd0) ? ($countones(m) % 2 == 1) :
           (psel == 2'd1) ? ($countones(m) % 2 == 0) : (psel == 2'd3);
    perr = pen && (pbit != want);
    ferr = !s1 || (two && !s2);
    brk  = (m == 8'd0) && !(pen && pbit) && !s1 && !(two && s2);
    return {brk, ferr, perr, m};
  endfunction

  task automatic set_cfg(input int div, input int nbits, input bit pen, input logic [1:0] psel, input bit two);
    cfg_div_i        = 16'(div);
    cfg_bits_i       = 2'(nbits - 5);
    cfg_parity_en_i  = pen;
    cfg_parity_sel_i = psel;
    cfg_stop_bits_i  = two;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                            input bit two, input bit s1, input bit s2);
    int bt;
    bt = int'(cfg_div_i) + 1;
    @(negedge clk_i);
    rx_i = 1'b0;
    t_fall = cyc;
    repeat (bt) @(negedge clk_i);
    for (int i = 0; i < nbits; i++) begin
      rx_i = d[i];
      repeat (bt) @(negedge clk_i);
    end
    if (pen) begin
      rx_i = pbit;
      repeat (bt) @(negedge clk_i);
    end
    rx_i = s1;
    repeat (bt) @(negedge clk_i);
    if (two) begin
      rx_i = s2;
      repeat (bt) @(negedge clk_i);
    end
    rx_i = 1'b1;
    repeat (6) @(negedge clk_i);
  endtask

  task automatic pop_one(output logic [9:0] got, output bit ok);
    @(negedge clk_i);
    ok  = rx_valid_o;
    got = {rx_ferr_o, rx_perr_o, rx_data_o};
    rx_ready_i = ok;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0; cfg_en_i = 1'b1; err_clr_i = 1'b0; rx_i = 1'b1; rx_ready_i = 1'b0;
    set_cfg(15, 8, 0, 2'd0, 0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid_o); end
    n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (break_o !== 1'b0) begin n_fail++; $display("FAIL reset_break: got %b expected 0", break_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    n_checks++; if ({rx_ferr_o, rx_perr_o, rx_data_o} !== 10'd0) begin n_fail++; $display("FAIL reset_head: got %h expected 0", {rx_ferr_o, rx_perr_o, rx_data_o}); end
  endtask

  task automatic test_basic;
    logic [9:0] got; bit ok; int lat;
    set_cfg(15, 8, 0, 2'd0, 0);
    valid_rise = -1;
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1);
    lat = valid_rise - t_fall;
    n_checks++; if (valid_rise < 0 || lat < 153 || lat > 156) begin n_fail++; $display("FAIL basic_latency: got %0d expected 153..156", lat); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy_o); end
    pop_one(got, ok);
    n_checks++; if (!ok || got !== {2'b00, 8'hA5}) begin n_fail++; $display("FAIL basic_entry: got %h valid %b expected %h", got, ok, {2'b00, 8'hA5}); end
    n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL basic_level_after_pop: got %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_parity;
    logic [9:0] got; bit ok; logic [10:0] e1, e2;
    // 0x35 has four ones: 0 is the correct even bit and the wrong odd bit.
    set_cfg(15, 7, 1, 2'd0, 0);
    e1 = model_frame(8'h35, 7, 1, 2'd0, 0, 0, 1, 1);
    send_frame(8'h35, 7, 1, 0, 0, 1, 1);
    set_cfg(15, 7, 1, 2'd1, 0);
    e2 = model_frame(8'h35, 7, 1, 2'd1, 0, 0, 1, 1);
    send_frame(8'h35, 7, 1, 0, 0, 1, 1);
    n_checks++; if (fifo_level_o !== 4'd2) begin n_fail++; $display("FAIL parity_level: got %0d expected 2", fifo_level_o); end
    pop_one(got, ok);
    n_checks++; if (!ok || got !== e1[9:0]) begin n_fail++; $display("FAIL parity_even: got %h expected %h", got, e1[9:0]); end
    pop_one(got, ok);
    n_checks++; if (!ok || got !== e2[9:0]) begin n_fail++; $display("FAIL parity_odd_wrong: got %h expected %h", got, e2[9:0]); end
  endtask

  task automatic test_stop_break;
    logic [9:0] got; bit ok; logic [10:0] e; int b0; int n;
    set_cfg(15, 8, 0, 2'd0, 1);
    e = model_frame(8'h5A, 8, 0, 2'd0, 0, 1, 1, 0);
    send_frame(8'h5A, 8, 0, 0, 1, 1, 0);
    pop_one(got, ok);
    n_checks++; if (!ok || got !== e[9:0]) begin n_fail++; $display("FAIL stop2_ferr: got %h expected %h", got, e[9:0]); end
    b0 = brk_cnt;
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (11 * 16 + 20) @(negedge clk_i);
    n_checks++; if (brk_cnt !== b0 + 1) begin n_fail++; $display("FAIL break_pulses: got %0d expected 1", brk_cnt - b0); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL break_busy_held: got %b expected 1", busy_o); end
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL break_no_push: got %b expected 0", rx_valid_o); end
    rx_i = 1'b1;
    n = 0;
    while (busy_o && n < 10) begin @(negedge clk_i); n++; end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL break_release: got busy %b expected 0 within 10 cycles", busy_o); end
  endtask

  task automatic test_false_start;
    int n;
    set_cfg(15, 8, 0, 2'd0, 0);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL false_start_seen: got busy %b expected 1", busy_o); end
    n = 0;
    while (busy_o && n < 9) begin @(negedge clk_i); n++; end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got busy %b expected 0 within 9 cycles", busy_o); end
    repeat (30) @(negedge clk_i);
    n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL false_start_no_push: got level %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_overrun;
    logic [9:0] exp_q[$]; logic [9:0] got; bit ok; logic [7:0] d;
    set_cfg(7, 8, 0, 2'd0, 0);
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      if (i < 8) exp_q.push_back({2'b00, d});
      if (i == 8) begin
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b expected 0", overrun_o); end
      end
      send_frame(d, 8, 0, 0, 0, 1, 1);
    end
    n_checks++; if (fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL overrun_level: got %0d expected 8", fifo_level_o); end
    n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun_o); end
    for (int i = 0; i < 8; i++) begin
      pop_one(got, ok);
      n_checks++; if (!ok || got !== exp_q[i]) begin n_fail++; $display("FAIL overrun_order[%0d]: got %h expected %h", i, got, exp_q[i]); end
    end
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL overrun_drained: got valid %b expected 0", rx_valid_o); end
    @(negedge clk_i); err_clr_i = 1'b1;
    @(negedge clk_i); err_clr_i = 1'b0;
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun_o); end
  endtask

  task automatic test_random;
    logic [9:0] got; bit ok; logic [10:0] e; logic [7:0] d;
    int div, nb, b0; bit pen, two, pbit, s1, s2; logic [1:0] psel;
    for (int k = 0; k < 12; k++) begin
      div  = $urandom_range(4, 12);
      nb   = $urandom_range(5, 8);
      pen  = 1'($urandom);
      psel = 2'($urandom);
      two  = 1'($urandom);
      pbit = 1'($urandom);
      s1   = ($urandom % 4) != 0;
      s2   = ($urandom % 4) != 0;
      d    = ($urandom % 5 == 0) ? 8'd0 : 8'($urandom);
      if (k == 3) begin d = 8'd0; pbit = 1'b0; s1 = 1'b0; s2 = 1'b0; end
      set_cfg(div, nb, pen, psel, two);
      e  = model_frame(d, nb, pen, psel, pbit, two, s1, s2);
      b0 = brk_cnt;
      send_frame(d, nb, pen, pbit, two, s1, s2);
      if (e[10]) begin
        n_checks++; if (brk_cnt !== b0 + 1 || rx_valid_o !== 1'b0) begin n_fail++; $display("FAIL random_break[%0d]: got pulses %0d valid %b expected 1 and 0", k, brk_cnt - b0, rx_valid_o); end
      end else begin
        pop_one(got, ok);
        n_checks++; if (!ok || got !== e[9:0] || brk_cnt !== b0) begin n_fail++; $display("FAIL random_entry[%0d]: got %h valid %b expected %h", k, got, ok, e[9:0]); end
      end
    end
  endtask

  task automatic test_midframe;
    logic [9:0] got; bit ok;
    set_cfg(15, 8, 0, 2'd0, 0);
    fork
      send_frame(8'hFF, 8, 0, 0, 0, 1, 1);
      begin
        repeat (60) @(negedge clk_i);
        cfg_en_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL disable_idle: got busy %b expected 0", busy_o); end
      end
    join
    repeat (5) @(negedge clk_i);
    cfg_en_i = 1'b1;
    repeat (5) @(negedge clk_i);
    n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL disable_no_push: got level %0d expected 0", fifo_level_o); end
    fork
      send_frame(8'hC3, 8, 0, 0, 0, 1, 1);
      begin
        repeat (40) @(negedge clk_i);
        cfg_bits_i = 2'b00;
      end
    join
    cfg_bits_i = 2'b11;
    pop_one(got, ok);
    n_checks++; if (!ok || got !== {2'b00, 8'hC3}) begin n_fail++; $display("FAIL cfg_shadow: got %h valid %b expected %h", got, ok, {2'b00, 8'hC3}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_stop_break;
    test_false_start;
    test_overrun;
    test_random;
    test_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
